pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 3-stage-fetch ARMv4 core. It drives the enables of the PC, IF/ID, ID/EX and EX/MEM registers. It turns stall, flush and interrupt conditions into per-cycle valid/bubble control, including the `i_inst_vld` / `i_irq_flag` inputs of the IF/ID register. It sits beside the datapath and holds all hazard priority and IRQ-tagging state in one place.

---
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 3-stage-fetch core: PC / IF/ID / ID/EX / EX/MEM
// enables, bubble insertion after redirects and stalls, and IRQ tagging of fetch slots.
module pipe_ctrl #(
    parameter int FLUSH_DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mem_wait,
    input  logic       i_branch_taken,
    input  logic       i_multi_busy,
    input  logic       i_load_use,
    input  logic       i_irq,
    input  logic       i_irq_taken,
    output logic       o_pc_en,
    output logic       o_if_id_en,
    output logic       o_fetch_vld,
    output logic       o_irq_flag,
    output logic       o_id_ex_en,
    output logic       o_id_ex_vld,
    output logic       o_ex_mem_en,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_CNT = FLUSH_DEPTH[1:0];

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       tagged_q, tagged_d;
    logic       tag_upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            cnt_q    <= 2'd0;
            tagged_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tagged_q <= tagged_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tagged_d    = tagged_q;
        tag_upd     = 1'b0;
        o_pc_en     = 1'b0;
        o_if_id_en  = 1'b0;
        o_fetch_vld = 1'b0;
        o_id_ex_en  = 1'b0;
        o_id_ex_vld = 1'b0;
        o_ex_mem_en = 1'b0;
        o_irq_flag  = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN, ST_FLUSH: begin
                    if (i_mem_wait) begin
                        // Freeze: nothing moves, control state held as-is.
                    end else if (i_branch_taken) begin
                        o_pc_en     = 1'b1;
                        o_if_id_en  = 1'b1;
                        o_id_ex_en  = 1'b1;
                        o_ex_mem_en = 1'b1;
                        state_d     = (FLUSH_DEPTH > 0) ? ST_FLUSH : ST_RUN;
                        cnt_d       = FLUSH_CNT;
                        // Any tagged slot was squashed (or accepted): re-tag after redirect.
                        tagged_d    = 1'b0;
                    end else if (i_multi_busy || i_load_use) begin
                        o_id_ex_en  = 1'b1;
                        o_ex_mem_en = 1'b1;
                        o_fetch_vld = (state_q == ST_RUN);
                        tag_upd     = 1'b1;
                    end else begin
                        o_pc_en     = 1'b1;
                        o_if_id_en  = 1'b1;
                        o_id_ex_en  = 1'b1;
                        o_id_ex_vld = 1'b1;
                        o_ex_mem_en = 1'b1;
                        o_fetch_vld = (state_q == ST_RUN);
                        tag_upd     = 1'b1;
                        if (state_q == ST_FLUSH) begin
                            cnt_d = cnt_q - 2'd1;
                            if (cnt_q <= 2'd1) begin
                                state_d = ST_RUN;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase

            o_irq_flag = (state_q == ST_RUN) && i_irq && !tagged_q
                         && o_if_id_en && o_fetch_vld;

            // Acceptance by EX takes precedence over a new tag in the same cycle.
            if (tag_upd) begin
                if (i_irq_taken) begin
                    tagged_d = 1'b0;
                end else if (o_irq_flag) begin
                    tagged_d = 1'b1;
                end
            end
        end
    end

    assign o_state = rst ? ST_BOOT : state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three instances (FLUSH_DEPTH 0, 1, 3) driven in lockstep and
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mw, bt, mb, lu, irq, it;
    logic [2:0] pc_en, if_id_en, fetch_vld, irq_flag, id_ex_en, id_ex_vld, ex_mem_en;
    logic [1:0] st [3];

    int n_tests = 0;
    int n_fail  = 0;

    int depth [3] = '{0, 1, 3};
    bit m_boot [3];
    int m_left [3];
    bit m_tag  [3];

    pipe_ctrl #(.FLUSH_DEPTH(0)) u_d0 (
        .clk(clk), .rst(rst), .i_mem_wait(mw), .i_branch_taken(bt), .i_multi_busy(mb),
        .i_load_use(lu), .i_irq(irq), .i_irq_taken(it),
        .o_pc_en(pc_en[0]), .o_if_id_en(if_id_en[0]), .o_fetch_vld(fetch_vld[0]),
        .o_irq_flag(irq_flag[0]), .o_id_ex_en(id_ex_en[0]), .o_id_ex_vld(id_ex_vld[0]),
        .o_ex_mem_en(ex_mem_en[0]), .o_state(st[0])
    );
    pipe_ctrl #(.FLUSH_DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .i_mem_wait(mw), .i_branch_taken(bt), .i_multi_busy(mb),
        .i_load_use(lu), .i_irq(irq), .i_irq_taken(it),
        .o_pc_en(pc_en[1]), .o_if_id_en(if_id_en[1]), .o_fetch_vld(fetch_vld[1]),
        .o_irq_flag(irq_flag[1]), .o_id_ex_en(id_ex_en[1]), .o_id_ex_vld(id_ex_vld[1]),
        .o_ex_mem_en(ex_mem_en[1]), .o_state(st[1])
    );
    pipe_ctrl #(.FLUSH_DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .i_mem_wait(mw), .i_branch_taken(bt), .i_multi_busy(mb),
        .i_load_use(lu), .i_irq(irq), .i_irq_taken(it),
        .o_pc_en(pc_en[2]), .o_if_id_en(if_id_en[2]), .o_fetch_vld(fetch_vld[2]),
        .o_irq_flag(irq_flag[2]), .o_id_ex_en(id_ex_en[2]), .o_id_ex_vld(id_ex_vld[2]),
        .o_ex_mem_en(ex_mem_en[2]), .o_state(st[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic w, input logic b, input logic m,
                          input logic l, input logic q, input logic t);
        rst = r; mw = w; bt = b; mb = m; lu = l; irq = q; it = t;
        #2;
    endtask

    function automatic logic [8:0] outs(int k);
        return {pc_en[k], if_id_en[k], fetch_vld[k], irq_flag[k],
                id_ex_en[k], id_ex_vld[k], ex_mem_en[k], st[k]};
    endfunction

    // Check every instance against the model for the current inputs, then advance a cycle.
    task automatic step();
        #3;
        for (int k = 0; k < 3; k++) begin
            logic pe, ie, fv, fl, de, dv, me;
            logic [1:0] s;
            bit run;
            pe = 0; ie = 0; fv = 0; fl = 0; de = 0; dv = 0; me = 0; s = 2'd0;
            run = (m_left[k] == 0);
            if (!rst && !m_boot[k]) begin
                s = run ? 2'd1 : 2'd2;
                if (mw) begin
                end else if (bt) begin
                    pe = 1; ie = 1; de = 1; me = 1;
                end else if (mb || lu) begin
                    de = 1; me = 1; fv = run;
                end else begin
                    pe = 1; ie = 1; de = 1; dv = 1; me = 1; fv = run;
                end
                fl = run && irq && !m_tag[k] && ie && fv;
            end
            chk($sformatf("d%0d_outputs", depth[k]), 32'(outs(k)),
                32'({pe, ie, fv, fl, de, dv, me, s}));

            if (rst) begin
                m_boot[k] = 1; m_left[k] = 0; m_tag[k] = 0;
            end else if (m_boot[k]) begin
                m_boot[k] = 0;
            end else if (mw) begin
            end else if (bt) begin
                m_left[k] = depth[k];
                m_tag[k]  = 0;
            end else begin
                if (!(mb || lu) && m_left[k] > 0) m_left[k]--;
                if (it) m_tag[k] = 0;
                else if (fl) m_tag[k] = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_boot[k] = 1; m_left[k] = 0; m_tag[k] = 0;
        end
        rst = 1; mw = 0; bt = 0; mb = 0; lu = 0; irq = 0; it = 0;
        @(posedge clk);
        #1;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0);
            chk("rst_pc_en", 32'(pc_en), 0);
            chk("rst_state", 32'(st[1]), 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("boot_state", 32'(st[1]), 0);
        chk("boot_fetch_vld", 32'(fetch_vld), 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("run_state", 32'(st[1]), 1);
        chk("first_fetch_vld", 32'(fetch_vld), 3'b111);
        step();
        for (int i = 0; i < 3; i++) step();

        // Branch redirect
        set_in(0, 0, 1, 0, 0, 0, 0);
        chk("br_T_fetch_vld", 32'(fetch_vld[1]), 0);
        chk("br_T_id_ex_vld", 32'(id_ex_vld[1]), 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("br_T1_state_d1", 32'(st[1]), 2);
        chk("br_T1_fetch_vld_d1", 32'(fetch_vld[1]), 0);
        chk("br_T1_fetch_vld_d0", 32'(fetch_vld[0]), 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("br_T2_state_d1", 32'(st[1]), 1);
        chk("br_T2_fetch_vld_d1", 32'(fetch_vld[1]), 1);
        chk("br_T2_state_d3", 32'(st[2]), 2);
        step();
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("br_T4_fetch_vld_d3", 32'(fetch_vld[2]), 1);
        step();

        // Load-use single bubble, then 4-cycle multi-cycle op
        set_in(0, 0, 0, 0, 1, 0, 0);
        chk("lu_pc_en", 32'(pc_en[1]), 0);
        chk("lu_if_id_en", 32'(if_id_en[1]), 0);
        chk("lu_id_ex_vld", 32'(id_ex_vld[1]), 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("lu_after_pc_en", 32'(pc_en[1]), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 1, 0, 0, 0);
            chk("mb_id_ex_vld", 32'(id_ex_vld[1]), 0);
            chk("mb_ex_mem_en", 32'(ex_mem_en[1]), 1);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("mb_after_pc_en", 32'(pc_en[1]), 1);
        step();

        // Priority: freeze beats branch and load-use
        set_in(0, 1, 1, 0, 1, 0, 0);
        chk("pri_enables", 32'({pc_en[1], if_id_en[1], id_ex_en[1], ex_mem_en[1]}), 0);
        step();
        set_in(0, 0, 1, 0, 1, 0, 0);
        chk("pri_state_held", 32'(st[1]), 1);
        chk("pri_branch_pc_en", 32'(pc_en[1]), 1);
        chk("pri_branch_fetch_vld", 32'(fetch_vld[1]), 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("pri_flush_state", 32'(st[1]), 2);
        for (int i = 0; i < 4; i++) step();

        // IRQ tag, squash and re-issue
        set_in(0, 0, 0, 0, 0, 1, 0);
        chk("irq_tag", 32'(irq_flag[1]), 1);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        chk("irq_once", 32'(irq_flag[1]), 0);
        step();
        set_in(0, 0, 1, 0, 0, 1, 0);
        chk("irq_squash_T", 32'(irq_flag[1]), 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        chk("irq_in_flush", 32'(irq_flag[1]), 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        chk("irq_reissue", 32'(irq_flag[1]), 1);
        step();
        set_in(0, 0, 0, 0, 0, 1, 1);
        chk("irq_taken_no_tag", 32'(irq_flag[1]), 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1);
        step();

        // IRQ during load-use stall
        set_in(0, 0, 0, 0, 1, 1, 0);
        chk("irq_stall_flag", 32'(irq_flag[1]), 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 0);
        chk("irq_after_stall_flag", 32'(irq_flag[1]), 1);
        chk("irq_after_stall_if_id", 32'(if_id_en[1]), 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1);
        step();

        // Randomized traffic
        irq = 0;
        for (int i = 0; i < 3000; i++) begin
            logic nirq;
            nirq = irq;
            if ($urandom_range(0, 99) < 6) nirq = ~irq;
            set_in(($urandom_range(0, 199) < 2), ($urandom_range(0, 99) < 10),
                   ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
                   ($urandom_range(0, 99) < 10), nirq, ($urandom_range(0, 99) < 8));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
